ram_readback_tx: RTL and testbench

//  Reads back the 8-byte parameter RAM, which the UART Rx path writes.
//  On request it sends a 10-byte UART 8N1 frame: header, RAM[0..7] in address order, then an XOR checksum.

---
 rtl/ram_tx_pkg.sv | 24 ++
 rtl/uart_tx_serializer.sv | 99 +++++++++
 rtl/ram_readback_tx.sv | 125 ++++++++++++
 tb/tb_ram_readback_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ram_tx_pkg.sv
// Shared types and constants for the parameter-RAM readback transmitter.
package ram_tx_pkg;

    localparam int          N_BYTES   = 8;
    localparam int          ADDR_W    = 3;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    // Character-level states used by the serializer.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_t;

    // Frame-level sequencing states used by the top.
    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DONE
    } seq_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART character serializer with a down-counting baud timer.
// A byte can be loaded while idle or in the last cycle of a stop bit, so
// back-to-back characters have no idle gap on the line.
//
//  state | meaning
//  IDLE  | line high, waiting for a byte
//  START | start bit (0) on the line
//  DATA  | eight data bits, LSB first
//  STOP  | stop bit (1); o_stop_first marks its first cycle
module uart_tx_serializer
    import ram_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_Tx,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_stop_first,
    output logic       o_tx
);

    localparam int             BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_bit_end;

    assign w_bit_end    = (r_baud == '0);
    assign o_ready      = (r_state == IDLE) || ((r_state == STOP) && w_bit_end);
    assign o_stop_first = (r_state == STOP) && (r_baud == BAUD_MAX);
    assign o_tx         = r_tx;

    // Bit sequencing: baud counter reloads at every bit boundary.
    always_ff @(posedge clk_Tx or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (o_ready && i_load) begin
            r_state <= START;
            r_tx    <= 1'b0;
            r_shift <= i_byte;
            r_baud  <= BAUD_MAX;
            r_bit   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_baud  <= BAUD_MAX;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= BAUD_MAX;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud - BW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_readback_tx.sv
// Parameter-RAM readback: sends header, RAM[0..N_BYTES-1], then the XOR of
// the RAM bytes as back-to-back UART characters. Each RAM byte is fetched
// during the stop bit of the preceding character, so no snapshot is kept and
// the checksum always covers exactly the bytes that went out.
//
//  state    | meaning
//  SEQ_IDLE | waiting for start
//  SEQ_RUN  | frame in progress, r_byte_idx = character on the line
//  SEQ_DONE | one-cycle done pulse; start here begins a new frame
module ram_readback_tx
    import ram_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk_Tx,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] r_addr,
    output logic              read,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int               IDX_W    = $clog2(N_BYTES + 2);
    localparam logic [IDX_W-1:0] PAY_END  = IDX_W'(N_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES + 1);

    seq_t             r_seq;
    logic [IDX_W-1:0] r_byte_idx;
    logic [7:0]       r_next;
    logic [7:0]       r_csum;
    logic             r_rd_d;
    logic             r_busy;
    logic             r_done;

    logic             w_ser_ready;
    logic             w_stop_first;
    logic             w_accept;
    logic             w_next_load;
    logic             w_load;
    logic [7:0]       w_byte;
    logic [IDX_W-1:0] w_idx_nxt;

    assign w_accept    = (r_seq != SEQ_RUN) && start;
    assign w_next_load = (r_seq == SEQ_RUN) && w_ser_ready && (r_byte_idx != LAST_IDX);
    assign w_load      = w_accept || w_next_load;
    assign w_idx_nxt   = r_byte_idx + IDX_W'(1);

    // Header on acceptance, checksum after the last payload byte, else prefetched RAM byte.
    assign w_byte = w_accept                ? SYNC_BYTE :
                    (r_byte_idx == PAY_END) ? r_csum    :
                                              r_next;

    // Fetch for the next payload byte happens in the first stop cycle of characters 0..N_BYTES-1.
    assign read = w_stop_first && (r_seq == SEQ_RUN) && (r_byte_idx < PAY_END);
    assign busy = r_busy;
    assign done = r_done;

    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk_Tx       (clk_Tx),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_byte       (w_byte),
        .o_ready      (w_ser_ready),
        .o_stop_first (w_stop_first),
        .o_tx         (tx)
    );

    // Frame sequencing, RAM capture and running checksum.
    always_ff @(posedge clk_Tx or negedge rst_n) begin
        if (!rst_n) begin
            r_seq      <= SEQ_IDLE;
            r_byte_idx <= '0;
            r_next     <= '0;
            r_csum     <= '0;
            r_rd_d     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_rd_d <= read;
            r_done <= 1'b0;
            if (r_rd_d) begin
                r_next <= ram_data;
                r_csum <= r_csum ^ ram_data;
            end
            case (r_seq)
                SEQ_IDLE, SEQ_DONE: begin
                    if (start) begin
                        r_seq      <= SEQ_RUN;
                        r_busy     <= 1'b1;
                        r_byte_idx <= '0;
                        r_csum     <= '0;
                        r_addr     <= '0;
                    end else begin
                        r_seq <= SEQ_IDLE;
                    end
                end
                SEQ_RUN: begin
                    if (w_ser_ready) begin
                        if (r_byte_idx == LAST_IDX) begin
                            r_seq  <= SEQ_DONE;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else begin
                            r_byte_idx <= w_idx_nxt;
                            if (w_idx_nxt < PAY_END) begin
                                r_addr <= w_idx_nxt[ADDR_W-1:0];
                            end
                        end
                    end
                end
                default: begin
                    r_seq  <= SEQ_IDLE;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_readback_tx.sv
// Directed bench for ram_readback_tx with an 8-cycle bit time and a
// registered-read RAM model.
module tb_ram_readback_tx;

    localparam int CPB = 8;

    logic       clk_Tx   = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [7:0] ram_data = 8'h00;
    logic [2:0] r_addr;
    logic       read;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] mem [0:7];

    int total = 0;
    int bad   = 0;

    always #5 clk_Tx = ~clk_Tx;

    // RAM with one-cycle registered read
    always @(posedge clk_Tx) begin
        if (read) ram_data <= mem[r_addr];
    end

    ram_readback_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_Tx   (clk_Tx),
        .rst_n    (rst_n),
        .start    (start),
        .ram_data (ram_data),
        .r_addr   (r_addr),
        .read     (read),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_ram_seq();
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    endtask

    // Runs one frame and checks it cycle by cycle. Cycle 1 is the first cycle
    // after the accepting edge; cycle 801 is the done cycle.
    task automatic run_frame(input string name, input logic [0:9][7:0] exp,
                             input bit chain, input bit repulse,
                             input int wr_cyc, input logic [7:0] wr_val,
                             input bit hold_next);
        logic [7:0] rx [10];
        int rcyc  [8];
        int raddr [8];
        int werr = 0, berr = 0, nrd = 0, ndone = 0, dcyc = 0;
        int b, pos;
        logic e;
        for (int i = 0; i < 10; i++) rx[i] = 8'h00;
        for (int i = 0; i < 8; i++) begin rcyc[i] = -1; raddr[i] = -1; end
        if (!chain) begin
            @(negedge clk_Tx);
            start = 1'b1;
        end
        @(negedge clk_Tx);
        start = 1'b0;
        for (int c = 1; c <= 801; c++) begin
            if (c > 1) @(negedge clk_Tx);
            if (c <= 800) begin
                b   = (c - 1) / CPB;
                pos = b % 10;
                if (pos == 0)      e = 1'b0;
                else if (pos == 9) e = 1'b1;
                else               e = exp[b / 10][pos - 1];
                if (((c - 1) % CPB) == CPB / 2 && pos >= 1 && pos <= 8)
                    rx[b / 10][pos - 1] = tx;
            end else begin
                e = 1'b1;
            end
            if (tx !== e) werr++;
            if (busy !== (c <= 800)) berr++;
            if (read === 1'b1) begin
                if (nrd < 8) begin
                    rcyc[nrd]  = c;
                    raddr[nrd] = int'(r_addr);
                end
                nrd++;
            end
            if (done === 1'b1) begin
                ndone++;
                dcyc = c;
            end
            if (wr_cyc == c) mem[7] = wr_val;
            start = (repulse && (c == 100 || c == 400)) || (hold_next && c == 801);
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("%s_byte%0d", name, i), 32'(rx[i]), 32'(exp[i]));
        chk({name, "_tx_wave_errs"}, werr, 0);
        chk({name, "_busy_errs"}, berr, 0);
        chk({name, "_read_count"}, nrd, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_read%0d_cycle", name, k), rcyc[k], (10 * k + 9) * CPB + 1);
            chk($sformatf("%s_read%0d_addr", name, k), raddr[k], k);
        end
        chk({name, "_done_count"}, ndone, 1);
        chk({name, "_done_cycle"}, dcyc, 801);
    endtask

    initial begin
        load_ram_seq();

        // reset held
        repeat (3) @(negedge clk_Tx);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", read, 0);
        chk("rst_addr", r_addr, 0);
        rst_n = 1'b1;
        @(negedge clk_Tx);

        // incrementing RAM, checksum 01^..^08 = 08
        run_frame("t2", {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08},
                  1'b0, 1'b0, 0, 8'h00, 1'b0);

        // all-ones payload, checksum 00
        for (int i = 0; i < 8; i++) mem[i] = 8'hFF;
        run_frame("t3", {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00},
                  1'b0, 1'b0, 0, 8'h00, 1'b0);

        // start while busy ignored; start in done cycle chains a new frame
        load_ram_seq();
        run_frame("t4a", {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08},
                  1'b0, 1'b1, 0, 8'h00, 1'b1);
        run_frame("t4b", {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08},
                  1'b1, 1'b0, 0, 8'h00, 1'b0);
        repeat (20) @(negedge clk_Tx);
        chk("t4_after_busy", busy, 0);
        chk("t4_after_tx", tx, 1);

        // reset mid-frame at cycle 300 (line is low for a data bit there)
        @(negedge clk_Tx);
        start = 1'b1;
        @(negedge clk_Tx);
        start = 1'b0;
        repeat (299) @(negedge clk_Tx);
        chk("t5_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_read", read, 0);
        chk("t5_rst_done", done, 0);
        @(negedge clk_Tx);
        rst_n = 1'b1;
        @(negedge clk_Tx);
        run_frame("t5", {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08},
                  1'b0, 1'b0, 0, 8'h00, 1'b0);

        // RAM[7] rewritten before its fetch; checksum 01^..^07^3C = 3C
        load_ram_seq();
        run_frame("t6", {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h3C, 8'h3C},
                  1'b0, 1'b0, 50, 8'h3C, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
